vc_fifo: RTL and testbench
==========================

// Module: vc_fifo
// PURPOSE
//  Multi-virtual-channel input buffer for NoC router ports. Holds NUM_VC independent FIFOs of
//  DEPTH flits each in one storage array; one write port and one read port, each addressed by VC id.
//  Uses the true-full rule: all DEPTH slots usable. Per-VC status feeds the router switch
//  allocator; optional credit return feeds the upstream link.
// PARAMETERS
//  WIDTH       32  flit width in bits (payload + address)
//  DEPTH_LOG2  2   log2 of per-VC depth; DEPTH = 1<<DEPTH_LOG2 (min 1)
//  NUM_VC      2   number of virtual channels (>=1)
//  VC_BITS     1   width of VC id; must be >= max(1, clog2(NUM_VC))
// PORTS
//  clk       in   1                      clock, rising edge
//  reset     in   1                      asynchronous, active-high
//  wr_en     in   1                      push request
//  wr_vc     in   VC_BITS                target VC of push
//  wr_data   in   WIDTH                  flit to push
//  rd_en     in   1                      pop request
//  rd_vc     in   VC_BITS                VC to pop / observe
//  rd_data   out  WIDTH                  head flit of rd_vc (combinational)
//  full      out  NUM_VC                 bit v = VC v holds DEPTH flits
//  empty     out  NUM_VC                 bit v = VC v holds 0 flits
//  count     out  NUM_VC*(DEPTH_LOG2+1)  packed per-VC occupancy, VC v at [v*(DEPTH_LOG2+1) +: DEPTH_LOG2+1]
//  overflow  out  1                      sticky: push to full VC or wr_vc >= NUM_VC
//  underflow out  1                      sticky: pop from empty VC or rd_vc >= NUM_VC
//  credit_valid out 1  / credit_vc out VC_BITS  (only with VC_FIFO_CREDIT_EN)
// BEHAVIOUR
//  - Reset (async): all rd/wr pointers 0, all counts 0, empty = all 1s, full = 0, overflow = 0,
//    underflow = 0, credit_valid = 0, credit_vc = 0. Storage contents not reset.
//  - Per VC v: rd_ptr[v], wr_ptr[v] of DEPTH_LOG2 bits, wrap modulo DEPTH; count[v] DEPTH_LOG2+1 bits.
//  - full[v] = (count[v] == DEPTH); empty[v] = (count[v] == 0); both from registered count.
//  - Push accepted iff wr_en && wr_vc < NUM_VC && !full[wr_vc]: mem[wr_vc][wr_ptr] <= wr_data, wr_ptr++.
//  - Pop accepted iff rd_en && rd_vc < NUM_VC && !empty[rd_vc]: rd_ptr++.
//  - Acceptance uses pre-edge state only: push into a full VC is dropped even if the same VC
//    is popped that cycle; pop from an empty VC is refused even if pushed that cycle (no bypass).
//  - Count update per VC: +1 on accepted push only, -1 on accepted pop only, unchanged if both
//    or neither. Push and pop on different VCs update both counts independently.
//  - Rejected push sets overflow; rejected pop sets underflow; both sticky until reset.
//  - rd_data = mem[rd_vc][rd_ptr[rd_vc]] when !empty[rd_vc]; else all zeros. Same-cycle pop
//    consumes the flit shown on rd_data; written data visible on rd_data the cycle after the push.
//  - Latency: push-to-visible 1 cycle; flow-through FIFO order per VC; no inter-VC ordering.
// CONFIGURATION
//  VC_FIFO_CREDIT_EN defined: credit_valid/credit_vc ports exist; registered — cycle after an
//    accepted pop, credit_valid = 1 and credit_vc = popped VC; else credit_valid = 0, credit_vc holds.
//  Not defined: ports absent, no credit logic; all other behaviour identical.
// TESTING
//  1. Reset, NUM_VC=2, DEPTH=4: empty=2'b11, full=0, counts 0, rd_data=0, overflow=underflow=0.
//  2. Push 0xA1..0xA4 to VC1 -> full=2'b10, count VC1=4; 5th push 0xA5 -> dropped, overflow=1;
//     pop x4 -> 0xA1,0xA2,0xA3,0xA4, then empty[1]=1.
//  3. Interleave push VC0 0x10,0x11 and VC1 0x20 -> pop VC1 yields 0x20, VC0 yields 0x10,0x11.
//  4. VC0 full, same-cycle push 0x55 + pop VC0 -> pop accepted, push dropped, count 3, overflow=1;
//     VC0 empty, push 0x66 + pop VC0 -> pop refused, underflow=1, count 1, next rd_data=0x66.
//  5. Push/pop 10 flits through VC0 at DEPTH=4 -> pointer wrap, data 0..9 in order, counts exact.
//  6. VC_FIFO_CREDIT_EN: pop VC1 at cycle t -> credit_valid=1, credit_vc=1 at t+1 only; assert
//     reset mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/vc_fifo.sv
// Multi-virtual-channel input buffer: NUM_VC independent true-full FIFOs in one array.
// Define VC_FIFO_CREDIT_EN to add the registered credit-return port.
module vc_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2,
    parameter int NUM_VC     = 2,
    parameter int VC_BITS    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [VC_BITS-1:0]               wr_vc,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             rd_en,
    input  logic [VC_BITS-1:0]               rd_vc,
    output logic [WIDTH-1:0]                 rd_data,
    output logic [NUM_VC-1:0]                full,
    output logic [NUM_VC-1:0]                empty,
    output logic [NUM_VC*(DEPTH_LOG2+1)-1:0] count,
    output logic                             overflow,
    output logic                             underflow
`ifdef VC_FIFO_CREDIT_EN
    ,
    output logic                             credit_valid,
    output logic [VC_BITS-1:0]               credit_vc
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem    [NUM_VC][DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr [NUM_VC];
    logic [DEPTH_LOG2-1:0] wr_ptr [NUM_VC];
    logic [CW-1:0]         cnt    [NUM_VC];

    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] rd_sel;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;

    // Out-of-range VC ids match no channel, so they fall out as rejects.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        push   = '0;
        pop    = '0;
        full   = '0;
        empty  = '0;
        count  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v] = (wr_vc == VC_BITS'(v));
            rd_sel[v] = (rd_vc == VC_BITS'(v));
            full[v]   = (cnt[v] == CW'(DEPTH));
            empty[v]  = (cnt[v] == '0);
            push[v]   = wr_en && wr_sel[v] && !full[v];
            pop[v]    = rd_en && rd_sel[v] && !empty[v];
            count[v*CW +: CW] = cnt[v];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_sel[v] && !empty[v]) begin
                rd_data = mem[v][rd_ptr[v]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push[v]) begin
                mem[v][wr_ptr[v]] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                cnt[v]    <= '0;
            end
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + DEPTH_LOG2'(1);
                end
                if (pop[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + DEPTH_LOG2'(1);
                end
                if (push[v] && !pop[v]) begin
                    cnt[v] <= cnt[v] + CW'(1);
                end else if (pop[v] && !push[v]) begin
                    cnt[v] <= cnt[v] - CW'(1);
                end
            end
            if (wr_en && !(|push)) begin
                overflow <= 1'b1;
            end
            if (rd_en && !(|pop)) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef VC_FIFO_CREDIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_valid <= 1'b0;
            credit_vc    <= '0;
        end else begin
            credit_valid <= |pop;
            if (|pop) begin
                credit_vc <= rd_vc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_fifo.sv
// Testbench for vc_fifo: directed scenarios plus random traffic against a queue model.
// Credit checks are compiled in when VC_FIFO_CREDIT_EN is defined.
module tb_vc_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        wr_vc;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        rd_vc;
    logic [31:0] rd_data;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;
`ifdef VC_FIFO_CREDIT_EN
    logic        credit_valid;
    logic        credit_vc;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          movf;
    bit          munf;

    vc_fifo #(
        .WIDTH(32), .DEPTH_LOG2(2), .NUM_VC(2), .VC_BITS(1)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_data),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
`ifdef VC_FIFO_CREDIT_EN
        , .credit_valid(credit_valid), .credit_vc(credit_vc)
`endif
    );

    always #5 clk = ~clk;

    function automatic int msize(input logic v);
        return (v == 1'b0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] mhead(input logic v);
        if (msize(v) == 0) return 32'h0;
        return (v == 1'b0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [5:0] mcount();
        return {3'(msize(1'b1)), 3'(msize(1'b0))};
    endfunction

    function automatic logic [1:0] mfull();
        return {msize(1'b1) == 4, msize(1'b0) == 4};
    endfunction

    function automatic logic [1:0] mempty();
        return {msize(1'b1) == 0, msize(1'b0) == 0};
    endfunction

    // Drive one clock of traffic and advance the model using pre-edge occupancy.
    task automatic cycle(input bit we, input logic wvc, input logic [31:0] wd,
                         input bit re, input logic rvc);
        bit pok;
        bit rok;
        wr_en   = we;
        wr_vc   = wvc;
        wr_data = wd;
        rd_en   = re;
        rd_vc   = rvc;
        pok = we && (msize(wvc) < 4);
        rok = re && (msize(rvc) > 0);
        @(posedge clk);
        if (we && !pok) movf = 1'b1;
        if (re && !rok) munf = 1'b1;
        if (rok) begin
            if (rvc == 1'b0) void'(q0.pop_front());
            else             void'(q1.pop_front());
        end
        if (pok) begin
            if (wvc == 1'b0) q0.push_back(wd);
            else             q1.push_back(wd);
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        q0.delete();
        q1.delete();
        movf = 1'b0;
        munf = 1'b0;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        wr_en = 0; wr_vc = 0; wr_data = 0; rd_en = 0; rd_vc = 0;
        reset = 1'b1;
        #12;
        checks++; if (empty !== 2'b11) begin errors++; $display("FAIL reset_empty got=%b exp=11", empty); end
        checks++; if (full !== 2'b00) begin errors++; $display("FAIL reset_full got=%b exp=00", full); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
`ifdef VC_FIFO_CREDIT_EN
        checks++; if ({credit_valid, credit_vc} !== 2'b00) begin errors++; $display("FAIL reset_credit got=%b exp=00", {credit_valid, credit_vc}); end
`endif
        reset = 1'b0;
        q0.delete(); q1.delete(); movf = 0; munf = 0;
        #1;
    endtask

    task automatic test_fill_vc1();
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1, 1'b1, 32'hA0 + 32'(i), 0, 1'b1);
        checks++; if (full !== 2'b10) begin errors++; $display("FAIL fill_full got=%b exp=10", full); end
        checks++; if (count[5:3] !== 3'd4) begin errors++; $display("FAIL fill_count1 got=%0d exp=4", count[5:3]); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
        cycle(1, 1'b1, 32'hA5, 0, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
        checks++; if (count[5:3] !== 3'd4) begin errors++; $display("FAIL fill_drop_count got=%0d exp=4", count[5:3]); end
        for (int i = 1; i <= 4; i++) begin
            exp = 32'hA0 + 32'(i);
            checks++; if (rd_data !== exp) begin errors++; $display("FAIL fill_pop%0d got=%h exp=%h", i, rd_data, exp); end
            cycle(0, 1'b0, 32'h0, 1, 1'b1);
        end
        checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL fill_empty1 got=%b exp=1", empty[1]); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL fill_rd_empty got=%h exp=0", rd_data); end
    endtask

    task automatic test_interleave();
        do_reset();
        cycle(1, 1'b0, 32'h10, 0, 1'b0);
        cycle(1, 1'b1, 32'h20, 0, 1'b0);
        cycle(1, 1'b0, 32'h11, 0, 1'b0);
        checks++; if (count !== 6'b001_010) begin errors++; $display("FAIL ilv_count got=%b exp=001010", count); end
        rd_vc = 1'b1; #1;
        checks++; if (rd_data !== 32'h20) begin errors++; $display("FAIL ilv_vc1 got=%h exp=20", rd_data); end
        cycle(0, 1'b0, 32'h0, 1, 1'b1);
        rd_vc = 1'b0; #1;
        checks++; if (rd_data !== 32'h10) begin errors++; $display("FAIL ilv_vc0a got=%h exp=10", rd_data); end
        cycle(0, 1'b0, 32'h0, 1, 1'b0);
        checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL ilv_vc0b got=%h exp=11", rd_data); end
        cycle(0, 1'b0, 32'h0, 1, 1'b0);
        checks++; if (empty !== 2'b11) begin errors++; $display("FAIL ilv_empty got=%b exp=11", empty); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 1'b0, 32'h50 + 32'(i), 0, 1'b0);
        cycle(1, 1'b0, 32'h55, 1, 1'b0);
        checks++; if (count[2:0] !== 3'd3) begin errors++; $display("FAIL same_full_count got=%0d exp=3", count[2:0]); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL same_ovf got=%b exp=1", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL same_unf_early got=%b exp=0", underflow); end
        checks++; if (rd_data !== 32'h51) begin errors++; $display("FAIL same_head got=%h exp=51", rd_data); end
        for (int i = 0; i < 3; i++) cycle(0, 1'b0, 32'h0, 1, 1'b0);
        cycle(1, 1'b0, 32'h66, 1, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL same_unf got=%b exp=1", underflow); end
        checks++; if (count[2:0] !== 3'd1) begin errors++; $display("FAIL same_empty_count got=%0d exp=1", count[2:0]); end
        checks++; if (rd_data !== 32'h66) begin errors++; $display("FAIL same_bypass got=%h exp=66", rd_data); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                checks++; if (rd_data !== 32'(i - 2)) begin errors++; $display("FAIL wrap_data%0d got=%h exp=%h", i, rd_data, 32'(i - 2)); end
            end
            cycle(i < 10, 1'b0, 32'(i), i >= 2, 1'b0);
            checks++; if (count !== mcount()) begin errors++; $display("FAIL wrap_count%0d got=%b exp=%b", i, count, mcount()); end
        end
        checks++; if ({empty[0], overflow, underflow} !== 3'b100) begin errors++; $display("FAIL wrap_end got=%b exp=100", {empty[0], overflow, underflow}); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < 55, 1'($urandom), $urandom,
                  $urandom_range(0, 99) < 45, 1'($urandom));
            rd_vc = 1'($urandom);
            #1;
            checks++; if (rd_data !== mhead(rd_vc)) begin errors++; $display("FAIL rnd_data%0d got=%h exp=%h", i, rd_data, mhead(rd_vc)); end
            checks++; if (count !== mcount()) begin errors++; $display("FAIL rnd_count%0d got=%b exp=%b", i, count, mcount()); end
            checks++; if (full !== mfull()) begin errors++; $display("FAIL rnd_full%0d got=%b exp=%b", i, full, mfull()); end
            checks++; if (empty !== mempty()) begin errors++; $display("FAIL rnd_empty%0d got=%b exp=%b", i, empty, mempty()); end
            checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_ovf%0d got=%b exp=%b", i, overflow, movf); end
            checks++; if (underflow !== munf) begin errors++; $display("FAIL rnd_unf%0d got=%b exp=%b", i, underflow, munf); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 1'b0, 32'h77, 0, 1'b0);
        cycle(1, 1'b1, 32'h78, 0, 1'b0);
        cycle(0, 1'b0, 32'h0, 1, 1'b1);
        cycle(1, 1'b1, 32'h79, 1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (empty !== 2'b11) begin errors++; $display("FAIL async_empty got=%b exp=11", empty); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL async_count got=%b exp=0", count); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL async_rd_data got=%h exp=0", rd_data); end
`ifdef VC_FIFO_CREDIT_EN
        checks++; if ({credit_valid, credit_vc} !== 2'b00) begin errors++; $display("FAIL async_credit got=%b exp=00", {credit_valid, credit_vc}); end
`endif
        reset = 1'b0;
        q0.delete(); q1.delete(); movf = 0; munf = 0;
    endtask

`ifdef VC_FIFO_CREDIT_EN
    task automatic test_credit();
        do_reset();
        cycle(1, 1'b1, 32'hC1, 0, 1'b1);
        cycle(1, 1'b0, 32'hC0, 0, 1'b1);
        checks++; if (credit_valid !== 1'b0) begin errors++; $display("FAIL cr_idle got=%b exp=0", credit_valid); end
        cycle(0, 1'b0, 32'h0, 1, 1'b1);
        checks++; if ({credit_valid, credit_vc} !== 2'b11) begin errors++; $display("FAIL cr_pop1 got=%b exp=11", {credit_valid, credit_vc}); end
        cycle(0, 1'b0, 32'h0, 0, 1'b0);
        checks++; if ({credit_valid, credit_vc} !== 2'b01) begin errors++; $display("FAIL cr_hold got=%b exp=01", {credit_valid, credit_vc}); end
        cycle(0, 1'b0, 32'h0, 1, 1'b1);
        checks++; if (credit_valid !== 1'b0) begin errors++; $display("FAIL cr_refused got=%b exp=0", credit_valid); end
        cycle(0, 1'b0, 32'h0, 1, 1'b0);
        checks++; if ({credit_valid, credit_vc} !== 2'b10) begin errors++; $display("FAIL cr_pop0 got=%b exp=10", {credit_valid, credit_vc}); end
    endtask
`endif

    initial begin
        movf = 0;
        munf = 0;
        test_reset();
        test_fill_vc1();
        test_interleave();
        test_same_cycle();
        test_wrap();
        test_random();
`ifdef VC_FIFO_CREDIT_EN
        test_credit();
`endif
        test_async_reset();
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
